// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue
//   Issue stage in front of a combinational 4-bit ALU. Commands {S,A,B} are
//   buffered in a DEPTH-entry FIFO. The head entry is driven straight out of
//   storage to the ALU; its result F is captured into an output register
//   that is handed downstream with a valid/ready handshake.
//
//   Optional feature macro: ALU_CHAIN_EN
//     When defined, each command carries a chain bit (IN_CHAIN). A chained
//     head entry takes operand A from LAST_F (the F of the most recent pop)
//     instead of its stored A.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   IN_VALID/IN_READY   upstream command handshake (IN_READY = not full)
//   IN_S, IN_A, IN_B    command opcode and operands
//   IN_CHAIN            (ALU_CHAIN_EN only) chain previous result into A
//   S, A, B             head command to the ALU (0 when queue is empty)
//   F                   ALU result for S/A/B
//   OUT_VALID/OUT_READY downstream result handshake
//   OUT_S, OUT_F        opcode and captured result
//   COUNT               FIFO occupancy, 0..DEPTH
module alu_cmd_queue #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [SEL_W-1:0]           IN_S,
  input  logic [WIDTH-1:0]           IN_A,
  input  logic [WIDTH-1:0]           IN_B,
`ifdef ALU_CHAIN_EN
  input  logic                       IN_CHAIN,
`endif
  output logic [SEL_W-1:0]           S,
  output logic [WIDTH-1:0]           A,
  output logic [WIDTH-1:0]           B,
  input  logic [WIDTH-1:0]           F,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [SEL_W-1:0]           OUT_S,
  output logic [WIDTH-1:0]           OUT_F,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {R_EMPTY = 1'b0, R_FULL = 1'b1} r_state_t;

  // Command storage
  logic [SEL_W-1:0] mem_s [DEPTH];
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  r_state_t         state_reg;
  logic [SEL_W-1:0] out_s_reg;
  logic [WIDTH-1:0] out_f_reg;

  logic push;
  logic pop;
  logic not_empty;
  logic [WIDTH-1:0] head_a;

  assign not_empty = (count_reg != '0);
  assign IN_READY  = (count_reg != CNT_W'(DEPTH));
  assign push      = IN_VALID & IN_READY;
  // The result register can take a new value when it is empty or is being
  // drained this cycle.
  assign pop       = not_empty & ((state_reg == R_EMPTY) | OUT_READY);

`ifdef ALU_CHAIN_EN
  logic             mem_chain [DEPTH];
  logic [WIDTH-1:0] last_f_reg;

  always_ff @(posedge CLK) begin
    if (push) mem_chain[wr_ptr_reg] <= IN_CHAIN;
  end

  // Result of the latest pop; survives draining, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)      last_f_reg <= '0;
    else if (pop) last_f_reg <= F;
  end

  assign head_a = mem_chain[rd_ptr_reg] ? last_f_reg : mem_a[rd_ptr_reg];
`else
  assign head_a = mem_a[rd_ptr_reg];
`endif

  // Storage write port; contents need no reset since COUNT gates the read.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_s[wr_ptr_reg] <= IN_S;
      mem_a[wr_ptr_reg] <= IN_A;
      mem_b[wr_ptr_reg] <= IN_B;
    end
  end

  // Head entry goes to the ALU with no extra register stage.
  assign S = not_empty ? mem_s[rd_ptr_reg] : '0;
  assign A = not_empty ? head_a            : '0;
  assign B = not_empty ? mem_b[rd_ptr_reg] : '0;

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Result stage FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= R_EMPTY;
      out_s_reg <= '0;
      out_f_reg <= '0;
    end else if (pop) begin
      state_reg <= R_FULL;
      out_s_reg <= S;
      out_f_reg <= F;
    end else if (OUT_READY) begin
      state_reg <= R_EMPTY;
    end
  end

  assign OUT_VALID = (state_reg == R_FULL);
  assign OUT_S     = out_s_reg;
  assign OUT_F     = out_f_reg;
  assign COUNT     = count_reg;

endmodule

// File: tb/tb_alu_cmd_queue.sv
module tb_alu_cmd_queue;

  localparam int WIDTH = 4;
  localparam int SEL_W = 3;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [SEL_W-1:0] IN_S;
  logic [WIDTH-1:0] IN_A;
  logic [WIDTH-1:0] IN_B;
`ifdef ALU_CHAIN_EN
  logic             IN_CHAIN;
`endif
  logic [SEL_W-1:0] S;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] F;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [SEL_W-1:0] OUT_S;
  logic [WIDTH-1:0] OUT_F;
  logic [2:0]       COUNT;

  typedef struct packed {
    logic [SEL_W-1:0] s;
    logic [WIDTH-1:0] f;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_last_f;
  int               checks   = 0;
  int               failures = 0;
  int               n;

  always #5 CLK = ~CLK;

  // Stub ALU: F = A + B mod 2^WIDTH
  assign F = A + B;

  alu_cmd_queue #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_S(IN_S), .IN_A(IN_A), .IN_B(IN_B),
`ifdef ALU_CHAIN_EN
    .IN_CHAIN(IN_CHAIN),
`endif
    .S(S), .A(A), .B(B), .F(F),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_S(OUT_S), .OUT_F(OUT_F), .COUNT(COUNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes that will fire at the coming edge,
  // then advance to the next falling edge where outputs are sampled.
  task automatic cycle();
    exp_t e;
    if (RST) begin
      sb.delete();
      model_last_f = '0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(OUT_VALID), 32'(0));
        end else begin
          e = sb.pop_front();
          check("out_s", 32'(OUT_S), 32'(e.s));
          check("out_f", 32'(OUT_F), 32'(e.f));
          $display("result S=%0d F=%0h", OUT_S, OUT_F);
        end
      end
      if (IN_VALID && IN_READY) begin
        e.s = IN_S;
        e.f = IN_A + IN_B;
`ifdef ALU_CHAIN_EN
        if (IN_CHAIN) e.f = model_last_f + IN_B;
`endif
        model_last_f = e.f;
        sb.push_back(e);
        $display("push S=%0d A=%0h B=%0h", IN_S, IN_A, IN_B);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    IN_VALID = 1'b1;
    IN_S = s;
    IN_A = a;
    IN_B = b;
  endtask

  // Drain everything with a cycle budget; returns cycles used.
  task automatic drain(output int cycles);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    cycles = 0;
    while ((OUT_VALID || COUNT != 0) && cycles < 30) begin
      cycle();
      cycles++;
    end
    check("drain_done", 32'(OUT_VALID || COUNT != 0), 32'(0));
    check("sb_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_S = '0; IN_A = '0; IN_B = '0; OUT_READY = 1'b0;
`ifdef ALU_CHAIN_EN
    IN_CHAIN = 1'b0;
`endif
    model_last_f = '0;
    @(negedge CLK);

    // 1. reset
    cycle(); cycle();
    RST = 1'b0;
    cycle();
    check("rst_out_valid", 32'(OUT_VALID), 32'(0));
    check("rst_count", 32'(COUNT), 32'(0));
    check("rst_sab", {S, A, B}, 32'(0));
    check("rst_in_ready", 32'(IN_READY), 32'(1));

    // 2. single command latency
    OUT_READY = 1'b1;
    drive(3'd5, 4'b1100, 4'b0011);
    cycle();
    IN_VALID = 1'b0;
    check("lat_a", 32'(A), 32'(4'b1100));
    check("lat_b", 32'(B), 32'(4'b0011));
    check("lat_s", 32'(S), 32'(5));
    check("lat_out_valid0", 32'(OUT_VALID), 32'(0));
    cycle();
    check("lat_out_valid1", 32'(OUT_VALID), 32'(1));
    check("lat_out_f", 32'(OUT_F), 32'(4'b1111));
    check("lat_out_s", 32'(OUT_S), 32'(5));
    cycle();
    check("lat_consumed", 32'(OUT_VALID), 32'(0));

    // 3. fill while stalled, then drain in order
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(SEL_W'(i), WIDTH'($urandom_range(15)), WIDTH'($urandom_range(15)));
      cycle();
    end
    check("full_count", 32'(COUNT), 32'(4));
    check("full_in_ready", 32'(IN_READY), 32'(0));
    check("full_head_result", 32'(OUT_S), 32'(0));
    drive(3'd7, 4'hF, 4'hF);
    cycle(); cycle();
    check("stall_count", 32'(COUNT), 32'(4));
    check("stall_out_s", 32'(OUT_S), 32'(0));
    check("stall_out_valid", 32'(OUT_VALID), 32'(1));
    drain(n);
    check("drain_cycles", 32'(n), 32'(5));

    // 4. steady state push+pop with pointer wrap
    OUT_READY = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(SEL_W'(i), WIDTH'($urandom_range(15)), WIDTH'($urandom_range(15)));
      cycle();
    end
    check("ss_count_start", 32'(COUNT), 32'(2));
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(SEL_W'(i + 2), WIDTH'($urandom_range(15)), WIDTH'($urandom_range(15)));
      cycle();
      check("ss_count", 32'(COUNT), 32'(2));
    end
    drain(n);

    // 5. reset mid-operation
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(SEL_W'(i + 3), WIDTH'(i + 1), WIDTH'(2 * i + 1));
      cycle();
    end
    check("pre_rst_count", 32'(COUNT), 32'(3));
    check("pre_rst_valid", 32'(OUT_VALID), 32'(1));
    IN_VALID = 1'b0;
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    check("mid_rst_count", 32'(COUNT), 32'(0));
    check("mid_rst_valid", 32'(OUT_VALID), 32'(0));
    check("mid_rst_out_f", 32'(OUT_F), 32'(0));
    check("mid_rst_out_s", 32'(OUT_S), 32'(0));
    check("mid_rst_sab", {S, A, B}, 32'(0));
    check("mid_rst_in_ready", 32'(IN_READY), 32'(1));
    OUT_READY = 1'b1;
    drive(3'd6, 4'h9, 4'h9);
    cycle();
    drain(n);

`ifdef ALU_CHAIN_EN
    // 6. chained operand A; model_last_f holds 2 from the post-reset command
    drive(3'd0, 4'd3, 4'd1);
    IN_CHAIN = 1'b0;
    cycle();
    drive(3'd1, 4'd9, 4'd2);
    IN_CHAIN = 1'b1;
    cycle();
    IN_CHAIN = 1'b0;
    IN_VALID = 1'b0;
    check("chain_first_f", 32'(OUT_F), 32'(4));
    check("chain_a_sub", 32'(A), 32'(4));
    cycle();
    check("chain_second_f", 32'(OUT_F), 32'(6));
    drain(n);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
